// File: rtl/fetch_buf.sv
// fetch_buf: pairs 1-cycle-latency instruction RAM data with its PC and queues it toward decode; define FETCH_BUF_BYPASS_EN for empty-queue bypass
module fetch_buf #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic [31:0] instr_addr_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        jump_flag_i,
  output logic        fetch_stall_o,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic          pend_q;
  logic [31:0]   pend_pc_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic          issue, capture, byp, push, pop, fifo_valid;
  logic [CW:0]   occ;
  // the in-flight read is reserved a slot, so a capture can never find the queue full
  assign occ = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
  assign fetch_stall_o = occ >= (CW + 1)'(DEPTH);
  assign issue = fetch_enable_i && !fetch_stall_o && !jump_flag_i;
  assign capture = pend_q && !jump_flag_i;
  assign fifo_valid = count_q != '0;
`ifdef FETCH_BUF_BYPASS_EN
  assign byp = capture && !fifo_valid;
`else
  assign byp = 1'b0;
`endif
  assign id_valid_o = !jump_flag_i && (fifo_valid || byp);
  assign id_instr_o = !id_valid_o ? '0 : byp ? instr_rdata_i : instr_mem[rd_ptr_q];
  assign id_pc_o = !id_valid_o ? '0 : byp ? pend_pc_q : pc_mem[rd_ptr_q];
  assign pop = id_valid_o && id_ready_i && fifo_valid;
  assign push = capture && !(byp && id_ready_i);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      pend_q <= 1'b0;
      pend_pc_q <= '0;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (jump_flag_i) begin
      pend_q <= 1'b0;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pend_q <= issue;
      if (issue) pend_pc_q <= instr_addr_i;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) begin
      instr_mem[wr_ptr_q] <= instr_rdata_i;
      pc_mem[wr_ptr_q] <= pend_pc_q;
    end
endmodule

// File: tb/tb_fetch_buf.sv
// tb_fetch_buf: scoreboard bench for fetch_buf; issued PCs are queued, a negedge monitor checks every decode handshake
module tb_fetch_buf;
  localparam int DEPTH = 4;
  localparam logic [31:0] K = 32'hA5A5_0000;
`ifdef FETCH_BUF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic clk_i = 1'b0, rst_ni = 1'b0, fetch_enable_i = 1'b0, jump_flag_i = 1'b0, id_ready_i = 1'b0;
  logic [31:0] instr_addr_i = '0, instr_rdata_i = '0;
  logic fetch_stall_o, id_valid_o;
  logic [31:0] id_instr_o, id_pc_o;
  int n_cmp = 0, n_err = 0;
  logic [31:0] expq[$];
  logic [31:0] pc = '0, last_addr = '0, tgt_q = '0, e_pc;
  logic issued = 1'b0, jumped = 1'b0;

  always #5 clk_i = ~clk_i;

  fetch_buf #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i),
    .instr_addr_i(instr_addr_i), .instr_rdata_i(instr_rdata_i), .jump_flag_i(jump_flag_i),
    .fetch_stall_o(fetch_stall_o), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // one cycle of prefetch + RAM model; ends 2 time units after the active edge
  task automatic step(input logic fe, input logic rdy, input logic jmp, input logic [31:0] tgt);
    @(posedge clk_i);
    #1;
    if (jumped) pc = tgt_q;
    else if (issued) pc = pc + 32'd4;
    instr_rdata_i = last_addr ^ K;
    instr_addr_i = pc;
    fetch_enable_i = fe;
    id_ready_i = rdy;
    jump_flag_i = jmp;
    if (jmp) expq.delete();
    issued = fe && !fetch_stall_o && !jmp && rst_ni;
    if (issued) expq.push_back(pc);
    jumped = jmp && rst_ni;
    tgt_q = tgt;
    last_addr = pc;
    #1;
  endtask

  task automatic hit_reset();
    rst_ni = 1'b0;
    expq.delete();
    pc = '0;
    issued = 1'b0;
    jumped = 1'b0;
  endtask

  always @(negedge clk_i)
    if (rst_ni) begin
      if (id_valid_o && id_ready_i) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got pc %h want no entry", id_pc_o);
        end else begin
          e_pc = expq.pop_front();
          chk("pop_pc", id_pc_o, e_pc);
          chk("pop_instr", id_instr_o, e_pc ^ K);
        end
      end
      if (!id_valid_o) chk("idle_zero", id_pc_o | id_instr_o, 32'h0);
      chk("push_when_full", 32'(dut.pend_q && !jump_flag_i && dut.count_q == DEPTH), 32'h0);
    end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    hit_reset();
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_valid", 32'(id_valid_o), 32'h0);
    chk("rst_stall", 32'(fetch_stall_o), 32'h0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_instr", id_instr_o, 32'h0);
    rst_ni = 1'b1;
    // boot stream with decode always ready
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("boot_valid0", 32'(id_valid_o), 32'h0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("boot_valid", 32'(id_valid_o), 32'(i >= LAT));
      chk("boot_stall", 32'(fetch_stall_o), 32'h0);
      if (i == LAT) chk("boot_first_pc", id_pc_o, 32'h0);
    end
    // fill with decode blocked, then drain
    hit_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst2_valid", 32'(id_valid_o), 32'h0);
    rst_ni = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("fill_stall", 32'(fetch_stall_o), 32'(i >= 4));
    end
    chk("fill_issued", 32'(expq.size()), 32'd4);
    chk("fill_head_pc", id_pc_o, 32'h0);
    chk("fill_addr_held", instr_addr_i, 32'h10);
    for (int i = 0; i <= 11; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("drain_valid", 32'(id_valid_o), 32'h1);
      chk("drain_stall", 32'(fetch_stall_o), 32'(i == 0));
    end
    // jump with three buffered and one in flight
    repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("empty_valid", 32'(id_valid_o), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    chk("jmp_valid_t", 32'(id_valid_o), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("jmp_valid", 32'(id_valid_o), 32'(i >= LAT + 1));
      if (i == 1) chk("jmp_stall_clr", 32'(fetch_stall_o), 32'h0);
      if (i == LAT + 1) chk("jmp_pc", id_pc_o, 32'h100);
    end
    // jump while stalled with a pop requested
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("js_stall", 32'(fetch_stall_o), 32'h1);
    chk("js_valid", 32'(id_valid_o), 32'h1);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    chk("js_valid_t", 32'(id_valid_o), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 1) chk("js_stall_t1", 32'(fetch_stall_o), 32'h0);
      if (i == 1) chk("js_valid_t1", 32'(id_valid_o), 32'h0);
      if (i == LAT + 1) chk("js_pc", id_pc_o, 32'h300);
    end
    // random ready/enable with periodic jumps
    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, (i % 37) == 36,
           {20'h0, 10'($urandom_range(0, 1023)), 2'b00});
    // reset with two entries buffered
    step(1'b1, 1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_pc", id_pc_o, 32'h40);
    hit_reset();
    #1;
    chk("mid_rst_valid", 32'(id_valid_o), 32'h0);
    chk("mid_rst_stall", 32'(fetch_stall_o), 32'h0);
    chk("mid_rst_pc", id_pc_o, 32'h0);
    chk("mid_rst_instr", id_instr_o, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == LAT) chk("restart_valid", 32'(id_valid_o), 32'h1);
      if (i == LAT) chk("restart_pc", id_pc_o, 32'h0);
    end
    repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("final_empty", 32'(expq.size()), 32'h0);
    chk("final_valid", 32'(id_valid_o), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
